// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - producer/FIFO write-port bundle for fifo_wr_arbiter (ARB_STALL_CNT_EN adds stall_cnt_o)
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64
);
  logic [NUM_REQ-1:0]            req_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] data_i;
  logic [NUM_REQ-1:0]            ready_o;
  logic                          fifo_full_i;
  logic                          fifo_wr_en_o;
  logic [DATA_WIDTH-1:0]         fifo_data_o;
  logic [NUM_REQ-1:0]            grant_o;
  logic                          busy_o;
`ifdef ARB_STALL_CNT_EN
  logic [15:0]                   stall_cnt_o;
`endif

  // master: the arbiter, which owns the FIFO write port
  modport master (
    input  req_i, data_i, fifo_full_i,
    output ready_o, fifo_wr_en_o, fifo_data_o, grant_o, busy_o
`ifdef ARB_STALL_CNT_EN
    , output stall_cnt_o
`endif
  );

  modport slave (
    output req_i, data_i, fifo_full_i,
    input  ready_o, fifo_wr_en_o, fifo_data_o, grant_o, busy_o
`ifdef ARB_STALL_CNT_EN
    , input stall_cnt_o
`endif
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers
// Optional ARB_STALL_CNT_EN: adds a saturating 16-bit count of full-stalled cycles.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BURST  = 4
) (
  input  logic             clk,
  input  logic             reset,
  fifo_wr_arbiter_if.master bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST) + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]          state;
  logic [NUM_REQ-1:0]  grant;
  logic [IW-1:0]       last_grant;
  logic [CW-1:0]       burst_cnt;
  logic [IW-1:0]       sel_idx;
  logic [IW-1:0]       cand;
  logic                sel_found;
  logic                beat;
  logic                burst_done;
  logic [DATA_WIDTH-1:0] data_mux;

  // Search starts just after the previous winner so every requester gets a turn.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IW'((int'(last_grant) + i) % NUM_REQ);
      if (!sel_found && bus.req_i[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // last_grant doubles as the granted index while BUSY.
  assign beat       = (state == BUSY) && bus.req_i[last_grant] && !bus.fifo_full_i;
  assign burst_done = beat && (burst_cnt == CW'(MAX_BURST - 1));

  always_comb begin
    data_mux = bus.data_i[DATA_WIDTH-1:0];
    for (int k = 0; k < NUM_REQ; k++) begin
      if ((state == BUSY) && (last_grant == IW'(k)))
        data_mux = bus.data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign bus.fifo_data_o  = data_mux;
  assign bus.fifo_wr_en_o = beat && !reset;
  assign bus.ready_o      = (beat && !reset) ? grant : '0;
  assign bus.grant_o      = grant;
  assign bus.busy_o       = (state == BUSY);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= IW'(NUM_REQ - 1);
      burst_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            state      <= BUSY;
            grant      <= NUM_REQ'(1) << sel_idx;
            last_grant <= sel_idx;
            burst_cnt  <= '0;
          end
        end
        BUSY: begin
          if (beat)
            burst_cnt <= burst_cnt + CW'(1);
          // Full alone never releases the grant; only a dropped request or a finished burst.
          if (!bus.req_i[last_grant] || burst_done) begin
            state <= IDLE;
            grant <= '0;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

`ifdef ARB_STALL_CNT_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if ((state == BUSY) && bus.req_i[last_grant] && bus.fifo_full_i && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end

  assign bus.stall_cnt_o = stall_cnt;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter (ARB_STALL_CNT_EN aware)
module tb_fifo_wr_arbiter;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   wr_count;
  logic [63:0] exp_data [4];

  fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(64)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(64), .MAX_BURST(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then drive the inputs that the next edge will sample.
  task automatic cycle(input logic [3:0] req, input logic full, input logic rst);
    @(posedge clk);
    #1;
    bus.req_i       = req;
    bus.fifo_full_i = full;
    reset           = rst;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_data[0] = 64'h1111_0000_0000_0000;
    exp_data[1] = 64'h2222_0000_0000_0001;
    exp_data[2] = 64'hA5A5_0000_0000_0001;
    exp_data[3] = 64'hD0D0_0000_0000_0003;
    bus.data_i      = {exp_data[3], exp_data[2], exp_data[1], exp_data[0]};
    bus.req_i       = 4'b1111;
    bus.fifo_full_i = 1'b0;
    reset           = 1'b1;

    // Reset held with all requests, then full rotation 0,1,2,3,0
    for (int i = 0; i < 3; i++) begin
      cycle(4'b1111, 1'b0, 1'b1);
      check_val("rst_grant", bus.grant_o, 4'b0000);
      check_val("rst_wr_en", bus.fifo_wr_en_o, 1'b0);
      check_val("rst_ready", bus.ready_o, 4'b0000);
    end
    cycle(4'b1111, 1'b0, 1'b0);
    check_val("rst_busy", bus.busy_o, 1'b0);
    cycle(4'b1111, 1'b0, 1'b0);
    check_val("first_grant", bus.grant_o, 4'b0001);
    wr_count = 0;
    for (int j = 0; j < 20; j++) begin
      if (j > 0) cycle(4'b1111, 1'b0, 1'b0);
      if (j % 5 == 4) begin
        check_val("rr_idle_grant", bus.grant_o, 4'b0000);
        check_val("rr_idle_wr_en", bus.fifo_wr_en_o, 1'b0);
      end else begin
        check_val("rr_grant", bus.grant_o, 4'b0001 << (j / 5));
        check_val("rr_ready", bus.ready_o, 4'b0001 << (j / 5));
        check_val("rr_data", bus.fifo_data_o, exp_data[j / 5]);
      end
      if (bus.fifo_wr_en_o) wr_count++;
    end
    check_val("rr_writes", wr_count, 16);
    cycle(4'b1111, 1'b0, 1'b0);
    check_val("rr_wrap_grant", bus.grant_o, 4'b0001);

    // Single requester 2, two beats, then request drops
    cycle(4'b0000, 1'b0, 1'b1);
    cycle(4'b0100, 1'b0, 1'b0);
    wr_count = 0;
    for (int j = 0; j < 2; j++) begin
      cycle(4'b0100, 1'b0, 1'b0);
      check_val("r2_grant", bus.grant_o, 4'b0100);
      check_val("r2_data", bus.fifo_data_o, 64'hA5A5_0000_0000_0001);
      if (bus.fifo_wr_en_o) wr_count++;
    end
    cycle(4'b0000, 1'b0, 1'b0);
    check_val("r2_drop_wr_en", bus.fifo_wr_en_o, 1'b0);
    cycle(4'b0000, 1'b0, 1'b0);
    check_val("r2_writes", wr_count, 2);
    check_val("r2_idle_grant", bus.grant_o, 4'b0000);
    check_val("r2_idle_busy", bus.busy_o, 1'b0);

    // Requester 1 stalled by full for 5 cycles after 2 beats
    cycle(4'b0000, 1'b0, 1'b1);
    cycle(4'b0010, 1'b0, 1'b0);
    for (int j = 0; j < 2; j++) begin
      cycle(4'b0010, 1'b0, 1'b0);
      check_val("full_pre_wr_en", bus.fifo_wr_en_o, 1'b1);
    end
    for (int j = 0; j < 5; j++) begin
      cycle(4'b0010, 1'b1, 1'b0);
      check_val("full_wr_en", bus.fifo_wr_en_o, 1'b0);
      check_val("full_ready", bus.ready_o, 4'b0000);
      check_val("full_grant", bus.grant_o, 4'b0010);
    end
    cycle(4'b0010, 1'b0, 1'b0);
    check_val("full_beat3_ready", bus.ready_o, 4'b0010);
`ifdef ARB_STALL_CNT_EN
    check_val("stall_cnt", bus.stall_cnt_o, 16'd5);
`endif
    cycle(4'b0010, 1'b0, 1'b0);
    check_val("full_beat4_wr_en", bus.fifo_wr_en_o, 1'b1);
    cycle(4'b0000, 1'b0, 1'b0);
    check_val("full_release_grant", bus.grant_o, 4'b0000);

    // Reset during beat 3 aborts the burst
    cycle(4'b0000, 1'b0, 1'b1);
    cycle(4'b0001, 1'b0, 1'b0);
    cycle(4'b0001, 1'b0, 1'b0);
    cycle(4'b0001, 1'b0, 1'b0);
    cycle(4'b0001, 1'b0, 1'b1);
    check_val("midrst_wr_en", bus.fifo_wr_en_o, 1'b0);
    check_val("midrst_ready", bus.ready_o, 4'b0000);
    cycle(4'b1111, 1'b0, 1'b0);
    check_val("midrst_grant", bus.grant_o, 4'b0000);
    check_val("midrst_busy", bus.busy_o, 1'b0);
`ifdef ARB_STALL_CNT_EN
    check_val("midrst_stall_cnt", bus.stall_cnt_o, 16'd0);
`endif
    cycle(4'b1111, 1'b0, 1'b0);
    check_val("midrst_regrant", bus.grant_o, 4'b0001);

    // Requester 3 granted; req 0 appearing mid-burst waits, then wins by wrap-around
    cycle(4'b0000, 1'b0, 1'b1);
    cycle(4'b1000, 1'b0, 1'b0);
    cycle(4'b1001, 1'b0, 1'b0);
    check_val("wrap_r3_data", bus.fifo_data_o, exp_data[3]);
    for (int j = 0; j < 4; j++) begin
      if (j > 0) cycle(4'b1001, 1'b0, 1'b0);
      check_val("wrap_r3_grant", bus.grant_o, 4'b1000);
    end
    cycle(4'b1001, 1'b0, 1'b0);
    check_val("wrap_idle", bus.grant_o, 4'b0000);
    cycle(4'b1001, 1'b0, 1'b0);
    check_val("wrap_grant", bus.grant_o, 4'b0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
